// File: rtl/prefix_adder_pipe.sv
// Brent-Kung adder/subtractor in a LAT-stage (1..3) elastic pipeline; every stage stalls together while out_valid && !out_ready.
// Defining PREFIX_ADDER_OVF_EN adds the registered signed-overflow output out_ovf.
module prefix_adder_pipe #(
  parameter int WIDTH = 8,
  parameter int LAT   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
`ifdef PREFIX_ADDER_OVF_EN
  output logic             out_ovf,
`endif
  output logic             out_cout
);

  localparam int L = $clog2(WIDTH);

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  logic [WIDTH-1:0] b_eff, g0, p0;
  logic             c0;
  assign b_eff = in_b ^ {WIDTH{in_sub}};
  assign g0    = in_a & b_eff;
  assign p0    = in_a ^ b_eff;
  assign c0    = in_cin ^ in_sub;

  logic [WIDTH-1:0] g1, p1;
  logic             c1, v1;
  if (LAT >= 2) begin : g_gp_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        v1 <= 1'b0;
        g1 <= '0;
        p1 <= '0;
        c1 <= 1'b0;
      end else if (adv) begin
        v1 <= in_valid;
        g1 <= g0;
        p1 <= p0;
        c1 <= c0;
      end
    end
  end else begin : g_gp_wire
    assign v1 = in_valid;
    assign g1 = g0;
    assign p1 = p0;
    assign c1 = c0;
  end

  // Carry-in is folded into bit 0's generate so the prefix tree yields carries directly.
  for (genvar l = 0; l <= L; l++) begin : up_lvl
    logic [WIDTH-1:0] g, p;
    if (l == 0) begin : g_init
      assign g = {g1[WIDTH-1:1], g1[0] | (p1[0] & c1)};
      assign p = p1;
    end else begin : g_comb
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (((i + 1) % (2 ** l)) == 0) begin : g_node
          assign g[i] = up_lvl[l-1].g[i] | (up_lvl[l-1].p[i] & up_lvl[l-1].g[i-2**(l-1)]);
          assign p[i] = up_lvl[l-1].p[i] & up_lvl[l-1].p[i-2**(l-1)];
        end else begin : g_pass
          assign g[i] = up_lvl[l-1].g[i];
          assign p[i] = up_lvl[l-1].p[i];
        end
      end
    end
  end

  logic [WIDTH-1:0] g2, pu2, p2;
  logic             c2, v2;
  if (LAT == 3) begin : g_up_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        v2  <= 1'b0;
        g2  <= '0;
        pu2 <= '0;
        p2  <= '0;
        c2  <= 1'b0;
      end else if (adv) begin
        v2  <= v1;
        g2  <= up_lvl[L].g;
        pu2 <= up_lvl[L].p;
        p2  <= p1;
        c2  <= c1;
      end
    end
  end else begin : g_up_wire
    assign v2  = v1;
    assign g2  = up_lvl[L].g;
    assign pu2 = up_lvl[L].p;
    assign p2  = p1;
    assign c2  = c1;
  end

  // Only down-sweep nodes consume the up-sweep group propagates.
  logic pu_unused;
  assign pu_unused = ^pu2;

  for (genvar k = 0; k < L; k++) begin : dn_lvl
    logic [WIDTH-1:0] g;
    if (k == 0) begin : g_init
      assign g = g2;
    end else begin : g_comb
      localparam int S = 2 ** (L - 1 - k);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if ((((i + 1) % (2 * S)) == S) && (i >= 3 * S - 1)) begin : g_node
          assign g[i] = dn_lvl[k-1].g[i] | (pu2[i] & dn_lvl[k-1].g[i-S]);
        end else begin : g_pass
          assign g[i] = dn_lvl[k-1].g[i];
        end
      end
    end
  end

  logic [WIDTH-1:0] co, cy, sum_c;
  assign co    = dn_lvl[L-1].g;
  assign cy    = {co[WIDTH-2:0], c2};
  assign sum_c = p2 ^ cy;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
`ifdef PREFIX_ADDER_OVF_EN
      out_ovf   <= 1'b0;
`endif
    end else if (adv) begin
      out_valid <= v2;
      out_sum   <= sum_c;
      out_cout  <= co[WIDTH-1];
`ifdef PREFIX_ADDER_OVF_EN
      out_ovf   <= cy[WIDTH-1] ^ co[WIDTH-1];
`endif
    end
  end

endmodule

// File: tb/tb_prefix_adder_pipe.sv
// Bench for prefix_adder_pipe: directed 8-bit/LAT=3 cases plus a WIDTH x LAT random sweep against an arithmetic model.
module tb_prefix_adder_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, in_valid, in_ready, in_cin, in_sub, out_valid, out_ready, out_cout;
  logic [7:0] in_a, in_b, out_sum;
`ifdef PREFIX_ADDER_OVF_EN
  logic       out_ovf;
`endif

  int checks = 0;
  int errors = 0;

  prefix_adder_pipe #(.WIDTH(8), .LAT(3)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
`ifdef PREFIX_ADDER_OVF_EN
    .out_ovf(out_ovf),
`endif
    .out_cout(out_cout)
  );

  logic        sw_valid, sw_cin, sw_sub;
  logic [63:0] sw_a, sw_b;
  logic [8:0]  sw_ovalid, sw_iready, sw_cout;
  logic [63:0] sw_sum [9];
`ifdef PREFIX_ADDER_OVF_EN
  logic [8:0]  sw_ovf;
`endif

  for (genvar wi = 0; wi < 3; wi++) begin : g_w
    for (genvar li = 0; li < 3; li++) begin : g_l
      localparam int W = (wi == 0) ? 4 : (wi == 1) ? 16 : 64;
      localparam int K = wi * 3 + li;
      logic [W-1:0] s;
      prefix_adder_pipe #(.WIDTH(W), .LAT(li + 1)) u_sw (
        .clk(clk), .rst(rst), .in_valid(sw_valid), .in_ready(sw_iready[K]),
        .in_a(sw_a[W-1:0]), .in_b(sw_b[W-1:0]), .in_cin(sw_cin), .in_sub(sw_sub),
        .out_valid(sw_ovalid[K]), .out_ready(1'b1), .out_sum(s),
`ifdef PREFIX_ADDER_OVF_EN
        .out_ovf(sw_ovf[K]),
`endif
        .out_cout(sw_cout[K])
      );
      assign sw_sum[K] = 64'(s);
    end
  end

  // Reference: {ovf, cout, sum} from plain w-bit arithmetic.
  function automatic logic [65:0] model(input logic [63:0] a, input logic [63:0] b,
                                        input logic cin, input logic sub, input int w);
    logic [64:0] m, r;
    logic [63:0] bb, s;
    logic        co, ov;
    m  = (65'd1 << w) - 65'd1;
    bb = sub ? ~b : b;
    r  = ({1'b0, a} & m) + ({1'b0, bb} & m) + {64'd0, cin ^ sub};
    s  = r[63:0] & m[63:0];
    co = r[w];
    ov = (a[w-1] == bb[w-1]) && (s[w-1] != a[w-1]);
    return {ov, co, s};
  endfunction

  task automatic cyc;
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [7:0] x, input logic [7:0] y, input logic ci, input logic su,
                       output logic [7:0] s, output logic co, output logic ov, output logic ok);
    cyc;
    in_a = x; in_b = y; in_cin = ci; in_sub = su; in_valid = 1'b1;
    cyc;
    in_valid = 1'b0;
    ok = 1'b0; s = '0; co = 1'b0; ov = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (out_valid) begin
        s = out_sum; co = out_cout; ok = 1'b1;
`ifdef PREFIX_ADDER_OVF_EN
        ov = out_ovf;
`endif
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0;
    cyc; cyc;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
    checks++; if (out_sum !== 8'h00 || out_cout !== 1'b0) begin errors++; $display("FAIL reset_data got %h/%b want 00/0", out_sum, out_cout); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", in_ready); end
`ifdef PREFIX_ADDER_OVF_EN
    checks++; if (out_ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b want 0", out_ovf); end
`endif
    cyc;
    rst = 1'b0;
  endtask

  task automatic test_latency;
    int lat;
    lat = 0;
    cyc;
    in_a = 8'd2; in_b = 8'd5; in_cin = 1'b0; in_sub = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    cyc;
    in_valid = 1'b0;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      if (out_valid) begin lat = n; break; end
      @(posedge clk); #1;
    end
    checks++; if (lat != 3) begin errors++; $display("FAIL latency got %0d want 3", lat); end
    checks++; if (out_sum !== 8'd7 || out_cout !== 1'b0) begin errors++; $display("FAIL add_2_5 got %h/%b want 07/0", out_sum, out_cout); end
  endtask

  task automatic test_carry_ovf;
    logic [7:0] s; logic co, ov, ok;
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, s, co, ov, ok);
    checks++; if (!ok || s !== 8'h00 || co !== 1'b1) begin errors++; $display("FAIL wrap_ff_01 got %h/%b ok=%b want 00/1", s, co, ok); end
`ifdef PREFIX_ADDER_OVF_EN
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL ovf_ff_01 got %b want 0", ov); end
`endif
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, s, co, ov, ok);
    checks++; if (!ok || s !== 8'h80 || co !== 1'b0) begin errors++; $display("FAIL add_7f_01 got %h/%b ok=%b want 80/0", s, co, ok); end
`ifdef PREFIX_ADDER_OVF_EN
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL ovf_7f_01 got %b want 1", ov); end
`endif
  endtask

  task automatic test_subtract;
    logic [7:0] s; logic co, ov, ok;
    do_op(8'd5, 8'h85, 1'b0, 1'b1, s, co, ov, ok);
    checks++; if (!ok || s !== 8'h80 || co !== 1'b0) begin errors++; $display("FAIL sub_5_85 got %h/%b ok=%b want 80/0", s, co, ok); end
`ifdef PREFIX_ADDER_OVF_EN
    checks++; if (ov !== 1'b1) begin errors++; $display("FAIL ovf_sub_5_85 got %b want 1", ov); end
`endif
    do_op(8'h85, 8'd5, 1'b0, 1'b1, s, co, ov, ok);
    checks++; if (!ok || s !== 8'h80 || co !== 1'b1) begin errors++; $display("FAIL sub_85_5 got %h/%b ok=%b want 80/1", s, co, ok); end
`ifdef PREFIX_ADDER_OVF_EN
    checks++; if (ov !== 1'b0) begin errors++; $display("FAIL ovf_sub_85_5 got %b want 0", ov); end
`endif
  endtask

  task automatic test_back_to_back;
    logic [7:0]  pa [10], pb [10];
    logic        pc [10], ps [10];
    logic [65:0] exp_q [$];
    logic [65:0] e;
    logic [7:0]  prev_s;
    logic        prev_c, stall;
    int          sent, got;
    for (int i = 0; i < 10; i++) begin
      pa[i] = 8'($urandom); pb[i] = 8'($urandom);
      pc[i] = 1'($urandom); ps[i] = 1'($urandom);
    end
    sent = 0; got = 0; prev_s = '0; prev_c = 1'b0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      cyc;
      stall = (c >= 4 && c <= 7);
      out_ready = !stall;
      if (sent < 10) begin
        in_valid = 1'b1; in_a = pa[sent]; in_b = pb[sent]; in_cin = pc[sent]; in_sub = ps[sent];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      checks++; if (in_ready !== !stall) begin errors++; $display("FAIL b2b_ready cyc %0d got %b want %b", c, in_ready, !stall); end
      if (c >= 5 && c <= 7) begin
        checks++;
        if (out_valid !== 1'b1 || out_sum !== prev_s || out_cout !== prev_c) begin
          errors++; $display("FAIL b2b_hold cyc %0d got %b/%h/%b want 1/%h/%b", c, out_valid, out_sum, out_cout, prev_s, prev_c);
        end
      end
      prev_s = out_sum; prev_c = out_cout;
      if (in_valid && in_ready) begin
        exp_q.push_back(model({56'd0, in_a}, {56'd0, in_b}, in_cin, in_sub, 8));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra got %h want none", out_sum);
        end else begin
          e = exp_q.pop_front();
          if (out_sum !== e[7:0] || out_cout !== e[64]) begin
            errors++; $display("FAIL b2b_data #%0d got %h/%b want %h/%b", got, out_sum, out_cout, e[7:0], e[64]);
          end
`ifdef PREFIX_ADDER_OVF_EN
          checks++; if (out_ovf !== e[65]) begin errors++; $display("FAIL b2b_ovf #%0d got %b want %b", got, out_ovf, e[65]); end
`endif
        end
        got++;
      end
    end
    checks++; if (got != 10) begin errors++; $display("FAIL b2b_count got %0d want 10", got); end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset_in_flight;
    int emitted;
    emitted = 0;
    cyc;
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; in_a = 8'($urandom); in_b = 8'($urandom); in_cin = 1'b0; in_sub = 1'b0;
      cyc;
    end
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flight_full got %b want 1", out_valid); end
    cyc;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL flight_rst got valid %b ready %b want 0 1", out_valid, in_ready); end
    checks++; if (out_sum !== 8'h00 || out_cout !== 1'b0) begin errors++; $display("FAIL flight_rst_data got %h/%b want 00/0", out_sum, out_cout); end
    cyc;
    rst = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (out_valid) emitted++;
      cyc;
    end
    checks++; if (emitted != 0) begin errors++; $display("FAIL flight_ghost got %0d results want 0", emitted); end
  endtask

  task automatic test_sweep;
    localparam int N = 1000;
    logic [63:0] va [N], vb [N];
    logic        vc [N], vs [N];
    logic [65:0] e;
    logic [63:0] m;
    int          w, lat, idx;
    logic        exp_v;
    for (int i = 0; i < N; i++) begin
      va[i] = {$urandom, $urandom}; vb[i] = {$urandom, $urandom};
      vc[i] = 1'($urandom); vs[i] = 1'($urandom);
    end
    for (int c = 0; c < N + 4; c++) begin
      cyc;
      if (c < N) begin
        sw_valid = 1'b1; sw_a = va[c]; sw_b = vb[c]; sw_cin = vc[c]; sw_sub = vs[c];
      end else begin
        sw_valid = 1'b0;
      end
      @(negedge clk);
      for (int k = 0; k < 9; k++) begin
        w   = (k / 3 == 0) ? 4 : (k / 3 == 1) ? 16 : 64;
        lat = k % 3 + 1;
        idx = c - lat;
        exp_v = (idx >= 0) && (idx < N);
        checks++; if (sw_iready[k] !== 1'b1) begin errors++; $display("FAIL sweep_ready w%0d l%0d cyc %0d got %b want 1", w, lat, c, sw_iready[k]); end
        checks++; if (sw_ovalid[k] !== exp_v) begin errors++; $display("FAIL sweep_valid w%0d l%0d cyc %0d got %b want %b", w, lat, c, sw_ovalid[k], exp_v); end
        if (exp_v) begin
          e = model(va[idx], vb[idx], vc[idx], vs[idx], w);
          m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
          checks++;
          if (sw_sum[k] !== (e[63:0] & m) || sw_cout[k] !== e[64]) begin
            errors++; $display("FAIL sweep_data w%0d l%0d vec %0d got %h/%b want %h/%b", w, lat, idx, sw_sum[k], sw_cout[k], e[63:0], e[64]);
          end
`ifdef PREFIX_ADDER_OVF_EN
          checks++; if (sw_ovf[k] !== e[65]) begin errors++; $display("FAIL sweep_ovf w%0d l%0d vec %0d got %b want %b", w, lat, idx, sw_ovf[k], e[65]); end
`endif
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sw_valid = 1'b0; sw_a = '0; sw_b = '0; sw_cin = 1'b0; sw_sub = 1'b0;
    test_reset;
    test_latency;
    test_carry_ovf;
    test_subtract;
    test_back_to_back;
    test_reset_in_flight;
    test_sweep;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prefix_adder_pipe.md
PREFIX_ADDER_PIPE -- requirements
Module: prefix_adder_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width; legal values 4, 8, 16, 32, 64 (power of two).
REQ-002 SHALL have parameter LAT, default 3: pipeline latency in cycles; legal values 1, 2, 3.
REQ-003 SHALL use one clock and a synchronous, active-high reset; all state changes on the rising edge of clk only.
REQ-004 SHALL have port clk, input, 1: clock.
REQ-005 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-006 SHALL have port in_valid, input, 1: an operand pair is offered.
REQ-007 SHALL have port in_ready, output, 1: the block accepts the pair this cycle.
REQ-008 SHALL have ports in_a and in_b, input, WIDTH each: operands.
REQ-009 SHALL have port in_cin, input, 1: carry-in.
REQ-010 SHALL have port in_sub, input, 1: subtract mode.
REQ-011 SHALL have port out_valid, output, 1: a result is presented.
REQ-012 SHALL have port out_ready, input, 1: the consumer takes the result.
REQ-013 SHALL have port out_sum, output, WIDTH: result.
REQ-014 SHALL have port out_cout, output, 1: carry-out.
REQ-015 SHALL have port out_ovf, output, 1: signed overflow; present only under REQ-031.

Function
REQ-016 SHALL compute {out_cout,out_sum} = in_a + (in_sub ? ~in_b : in_b) + (in_cin ^ in_sub), modulo 2^(WIDTH+1).
REQ-017 SHALL build the carry network as a Brent-Kung parallel prefix: up-sweep of log2(WIDTH) levels, then down-sweep of log2(WIDTH)-1 levels, using generate/propagate pairs.
REQ-018 SHALL NOT use behavioural "+" for the sum path.
REQ-019 SHALL place registers by LAT:
  - LAT=1: output register only.
  - LAT=2: registers after g/p generation and at the output.
  - LAT=3: registers after g/p generation, after the up-sweep, and at the output.
REQ-020 SHALL produce the result exactly LAT cycles after acceptance when out_ready is held high.
REQ-021 SHALL run the pipeline as a single-enable elastic pipeline:
  - adv = !out_valid || out_ready.
  - in_ready = adv (combinational).
  - Each stage register and its valid bit load only when adv=1.
REQ-022 SHALL accept a transfer when in_valid && in_ready are both high in the same cycle; a bubble (in_valid=0 with adv=1) SHALL propagate as valid=0.
REQ-023 SHALL sustain a throughput of one result per cycle when out_ready is held high.
REQ-024 SHALL hold out_sum, out_cout and out_ovf stable while out_valid=1 and out_ready=0.
REQ-025 SHALL neither drop nor duplicate any accepted operand pair across a stall of any length.
REQ-026 SHALL admit a new operand in the same cycle as the last result is consumed (out_ready=1 with a full pipeline).
REQ-027 SHALL wrap modulo 2^WIDTH on unsigned overflow, with the carry reported on out_cout.

Reset
REQ-028 SHALL clear all stage valid bits on rst=1; out_valid=0 the cycle after rst is sampled high.
REQ-029 SHALL drive out_sum=0, out_cout=0 and out_ovf=0 after reset.
REQ-030 SHALL discard all in-flight data on a reset mid-operation; in_ready SHALL be 1 while rst=1 because out_valid is 0.

Configuration
REQ-031 SHALL, when macro PREFIX_ADDER_OVF_EN is defined:
  - Compile in port out_ovf = carry into MSB XOR carry out of MSB.
  - Register out_ovf alongside out_sum.
REQ-032 SHALL, when PREFIX_ADDER_OVF_EN is undefined, omit the port and its logic entirely; all other behaviour is unchanged.

Verification
REQ-033 SHALL cover: WIDTH=8, LAT=3, a=2, b=5, cin=0, sub=0, out_ready=1 -> out_sum=7, cout=0, out_valid high exactly 3 cycles after acceptance.
REQ-034 SHALL cover: WIDTH=8, a=8'hFF, b=8'h01, cin=0 -> out_sum=8'h00, cout=1; with OVF_EN, ovf=0. Then a=8'h7F, b=8'h01 -> sum=8'h80, ovf=1.
REQ-035 SHALL cover: sub=1, a=5, b=133 (8'h85), WIDTH=8 -> out_sum=8'h80, cout=0; and a=133, b=5 -> out_sum=8'h80, cout=1.
REQ-036 SHALL cover: a back-to-back stream of 10 random pairs with out_ready low for cycles 4-7:
  - in_ready low during the stall;
  - outputs held constant;
  - all 10 results delivered in order and matching a reference model.
REQ-037 SHALL cover: rst asserted with 3 results in flight -> out_valid=0 next cycle, none of those 3 results ever emitted.
REQ-038 SHALL cover: a sweep of WIDTH in {4,16,64} x LAT in {1,2,3} with 1000 random vectors each -> zero mismatches, latency equal to LAT.
